// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, LSB-first deserialiser with a one-cycle done strobe and
// a framing-error flag for the stop bit.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int unsigned NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]  SLast = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast = NW'(DBIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            frame_err_q, frame_err_d;
  logic            done_q, done_d;

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        // Mid start bit: a high line here was only a glitch.
        if (s_tick && (s_q == 5'd7)) state_d = rx_s_q ? StIdle : StData;
      end
      StData: begin
        if (s_tick && (s_q == 5'd15) && (n_q == NLast)) state_d = StStop;
      end
      StStop: begin
        if (s_tick && (s_q == SLast)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    dout_d      = dout_q;
    frame_err_d = frame_err_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s_q) s_d = '0;
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == 5'd7) begin
            s_d = '0;
            n_d = '0;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q != NLast) n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == SLast) begin
            s_d         = '0;
            dout_d      = b_q;
            frame_err_d = ~rx_s_q;
            done_d      = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: s_d = '0;
    endcase
  end

  assign dout         = dout_q;
  assign frame_err    = frame_err_q;
  assign rx_done_tick = done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance with one stop tick window of 16, one with 32.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       s_tick;
  logic [7:0] dout1, dout2;
  logic       done1, done2;
  logic       ferr1, ferr2;

  int checks = 0;
  int errors = 0;
  int div = 4;
  int tick_cnt = 0;
  int cyc = 0;
  int done1_cnt = 0, done2_cnt = 0;
  int last1 = 0, last2 = 0;
  int dbl = 0;
  int start_cyc = 0;
  logic prev1 = 1'b0, prev2 = 1'b0;
  logic [7:0] q1[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) u_dut1 (
    .clk          (clk),
    .reset        (rst_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout1),
    .rx_done_tick (done1),
    .frame_err    (ferr1)
  );

  uart_rx #(.DBIT(8), .SB_TICK(32)) u_dut2 (
    .clk          (clk),
    .reset        (rst_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout2),
    .rx_done_tick (done2),
    .frame_err    (ferr2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_cnt >= div - 1) begin
        tick_cnt = 0;
        s_tick   = 1'b1;
      end else begin
        tick_cnt++;
        s_tick = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (done1) begin
      done1_cnt++;
      last1 = cyc;
      q1.push_back(dout1);
      if (prev1) dbl++;
    end
    if (done2) begin
      done2_cnt++;
      last2 = cyc;
      if (prev2) dbl++;
    end
    prev1 = done1;
    prev2 = done2;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int ticks);
    rx = v;
    repeat (ticks * div) @(negedge clk);
  endtask

  // Starts at a negedge and ends at one, so consecutive calls are truly back-to-back.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int nstop);
    start_cyc = cyc;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
    if (stop_v) begin
      drive_bit(1'b1, 16 * nstop);
    end else begin
      drive_bit(1'b0, 11);
      drive_bit(1'b1, 5);
    end
  endtask

  initial begin
    int c;
    int c2;
    logic [7:0] v;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_dout", dout1, 8'h00);
    check("reset_ferr", ferr1, 1'b0);
    check("reset_done", done1, 1'b0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    // 1: clean 0x55
    c = done1_cnt;
    send_frame(8'h55, 1'b1, 1);
    repeat (8) @(negedge clk);
    check("t1_done_cnt", done1_cnt - c, 1);
    check("t1_dout", dout1, 8'h55);
    check("t1_ferr", ferr1, 1'b0);

    // 2: 5-tick glitch is rejected
    c = done1_cnt;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 48);
    check("t2_done_cnt", done1_cnt - c, 0);
    check("t2_dout_held", dout1, 8'h55);

    // 3: stop bit low, then a clean frame clears the error
    c = done1_cnt;
    send_frame(8'hA3, 1'b0, 1);
    drive_bit(1'b1, 48);
    check("t3_done_cnt", done1_cnt - c, 1);
    check("t3_dout", dout1, 8'hA3);
    check("t3_ferr", ferr1, 1'b1);
    send_frame(8'h0F, 1'b1, 1);
    repeat (8) @(negedge clk);
    check("t3b_dout", dout1, 8'h0F);
    check("t3b_ferr", ferr1, 1'b0);

    // 4: back-to-back frames
    q1.delete();
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    repeat (8) @(negedge clk);
    check("t4_count", q1.size(), 2);
    v = (q1.size() > 0) ? q1[0] : 8'hxx;
    check("t4_first", v, 8'h00);
    v = (q1.size() > 1) ? q1[1] : 8'hxx;
    check("t4_second", v, 8'hFF);

    // 5: reset during data bit 3 of 0x3C
    c = done1_cnt;
    v = 8'h3C;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(v[i], 16);
    drive_bit(v[3], 8);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_rst_dout", dout1, 8'h00);
    check("t5_rst_ferr", ferr1, 1'b0);
    check("t5_rst_done", done1, 1'b0);
    rst_n = 1'b1;
    drive_bit(1'b1, 48);
    check("t5_no_done", done1_cnt - c, 0);
    send_frame(8'h3C, 1'b1, 1);
    repeat (8) @(negedge clk);
    check("t5_dout", dout1, 8'h3C);

    // 6: s_tick every cycle, two stop bits
    rst_n = 1'b0;
    div   = 1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    c  = done1_cnt;
    c2 = done2_cnt;
    send_frame(8'h81, 1'b1, 2);
    repeat (20) @(negedge clk);
    check("t6_done1_cnt", done1_cnt - c, 1);
    check("t6_dout1", dout1, 8'h81);
    check("t6_ferr1", ferr1, 1'b0);
    check("t6_lat1", last1 - start_cyc, 155);
    check("t6_done2_cnt", done2_cnt - c2, 1);
    check("t6_dout2", dout2, 8'h81);
    check("t6_ferr2", ferr2, 1'b0);
    check("t6_lat2", last2 - start_cyc, 171);

    check("no_double_done", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
